// File: rtl/apb_mux_tmo_pkg.sv
// Shared types and sizing helpers for the APB interconnect with decode error and watchdog.
package apb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DECERR = 2'd2
  } apb_mux_state_t;

  localparam int MAX_SLAVES = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_mux_tmo_if.sv
// Master-side APB3 signals seen by the interconnect.
interface apb_mux_tmo_if #(
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = 32
) ();

  logic                  MST_PSEL;
  logic                  MST_PENABLE;
  logic [PADDR_SIZE-1:0] MST_PADDR;
  logic [PDATA_SIZE-1:0] MST_PRDATA;
  logic                  MST_PREADY;
  logic                  MST_PSLVERR;

  modport master (
    output MST_PSEL, MST_PENABLE, MST_PADDR,
    input  MST_PRDATA, MST_PREADY, MST_PSLVERR
  );

  modport slave (
    input  MST_PSEL, MST_PENABLE, MST_PADDR,
    output MST_PRDATA, MST_PREADY, MST_PSLVERR
  );

endinterface

// File: rtl/apb_mux_tmo_addr_decoder.sv
// Window compare per slave plus lowest-index priority encode; a zero mask disables a window.
module apb_addr_decoder
  import apb_mux_pkg::*;
#(
  parameter  int PADDR_SIZE = 12,
  parameter  int SLAVES     = 4,
  localparam int IDX_W      = idx_width(SLAVES)
) (
  input  logic [PADDR_SIZE-1:0] paddr,
  input  logic [PADDR_SIZE-1:0] slv_addr [SLAVES],
  input  logic [PADDR_SIZE-1:0] slv_mask [SLAVES],
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [SLAVES-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int s = 0; s < SLAVES; s++) begin
      hit_vec[s] = (|slv_mask[s]) &&
                   ((paddr & slv_mask[s]) == (slv_addr[s] & slv_mask[s]));
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (hit_vec[s]) begin
        hit = 1'b1;
        idx = IDX_W'(s);
      end
    end
  end

endmodule

// File: rtl/apb_mux_tmo.sv
// APB3 1-to-N interconnect: decode, held slave index, DECERR response, PREADY watchdog, sticky flags.
//   state  | meaning
//   IDLE   | waiting for setup; decode drives SLV_PSEL combinationally
//   ACCESS | routed to sel_idx until PREADY or watchdog expiry
//   DECERR | unmapped address, zero-wait error response
module apb_mux_tmo
  import apb_mux_pkg::*;
#(
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = 32,
  parameter int SLAVES     = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_mux_tmo_if.slave          mst,
  input  logic [PADDR_SIZE-1:0] slv_addr    [SLAVES],
  input  logic [PADDR_SIZE-1:0] slv_mask    [SLAVES],
  output logic [SLAVES-1:0]     SLV_PSEL,
  input  logic [PDATA_SIZE-1:0] SLV_PRDATA  [SLAVES],
  input  logic [SLAVES-1:0]     SLV_PREADY,
  input  logic [SLAVES-1:0]     SLV_PSLVERR,
  output logic                  tmo_o,
  output logic                  decerr_o,
  output logic [SLAVES-1:0]     tmo_status_o,
  input  logic                  clr_status_i
);

  localparam int IDX_W = idx_width(SLAVES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_mux_state_t  state, state_nxt;
  logic [IDX_W-1:0] sel_idx, sel_idx_nxt;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_hit;
  logic             setup;
  logic             sel_ready;
  logic             tmo_fire;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [PDATA_SIZE-1:0] prdata;
  logic             pready;
  logic             pslverr;
  logic [SLAVES-1:0] status_nxt;

  apb_addr_decoder #(
    .PADDR_SIZE (PADDR_SIZE),
    .SLAVES     (SLAVES)
  ) u_dec (
    .paddr    (mst.MST_PADDR),
    .slv_addr (slv_addr),
    .slv_mask (slv_mask),
    .hit      (dec_hit),
    .idx      (dec_idx)
  );

  assign setup     = mst.MST_PSEL & ~mst.MST_PENABLE;
  assign sel_ready = SLV_PREADY[sel_idx];

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          cnt <= '0;
        end else if (cnt_clr) begin
          cnt <= '0;
        end else if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
          cnt <= cnt + 1'b1;
        end
      end

      // A ready slave in the expiry cycle takes precedence over the watchdog.
      assign tmo_fire = (state == ACCESS) && mst.MST_PSEL && !sel_ready &&
                        (cnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign tmo_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      sel_idx <= '0;
    end else begin
      state   <= state_nxt;
      sel_idx <= sel_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_idx_nxt = sel_idx;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    SLV_PSEL    = '0;
    prdata      = '0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    tmo_o       = 1'b0;
    decerr_o    = 1'b0;

    case (state)
      IDLE: begin
        if (setup) begin
          cnt_clr = 1'b1;
          if (dec_hit) begin
            SLV_PSEL[dec_idx] = 1'b1;
            sel_idx_nxt       = dec_idx;
            state_nxt         = ACCESS;
          end else begin
            state_nxt = DECERR;
          end
        end
      end

      ACCESS: begin
        if (!mst.MST_PSEL) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_fire) begin
          pready    = 1'b1;
          pslverr   = 1'b1;
          tmo_o     = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          SLV_PSEL[sel_idx] = 1'b1;
          pready            = sel_ready;
          pslverr           = SLV_PSLVERR[sel_idx];
          if (sel_ready) begin
            prdata    = SLV_PRDATA[sel_idx];
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      DECERR: begin
        if (mst.MST_PSEL) begin
          pready   = 1'b1;
          pslverr  = 1'b1;
          decerr_o = 1'b1;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mst.MST_PRDATA  = prdata;
  assign mst.MST_PREADY  = pready;
  assign mst.MST_PSLVERR = pslverr;

  // A timeout in the same cycle as a clear still leaves its own flag set.
  always_comb begin
    status_nxt = clr_status_i ? '0 : tmo_status_o;
    if (tmo_o) begin
      status_nxt[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tmo_status_o <= '0;
    end else begin
      tmo_status_o <= status_nxt;
    end
  end

endmodule

// File: tb/tb_apb_mux_tmo.sv
// Directed cycle-by-cycle vectors for apb_mux_tmo (4 slaves, watchdog of 8 cycles).
module tb_apb_mux_tmo;

  localparam logic [31:0] D0 = 32'h0000_A0A0;
  localparam logic [31:0] D1 = 32'h0000_CAFE;
  localparam logic [31:0] D2 = 32'h0000_2222;
  localparam logic [31:0] D3 = 32'h0000_3333;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] slv_addr   [4];
  logic [11:0] slv_mask   [4];
  logic [3:0]  slv_psel;
  logic [31:0] slv_prdata [4];
  logic [3:0]  slv_pready;
  logic [3:0]  slv_pslverr;
  logic        tmo;
  logic        decerr;
  logic [3:0]  tmo_status;
  logic        clr_status;

  int passed = 0;
  int total  = 0;

  apb_mux_tmo_if #(.PADDR_SIZE(12), .PDATA_SIZE(32)) bus ();

  apb_mux_tmo #(
    .PADDR_SIZE (12),
    .PDATA_SIZE (32),
    .SLAVES     (4),
    .TIMEOUT    (8)
  ) dut (
    .PCLK         (clk),
    .PRESET       (rst),
    .mst          (bus),
    .slv_addr     (slv_addr),
    .slv_mask     (slv_mask),
    .SLV_PSEL     (slv_psel),
    .SLV_PRDATA   (slv_prdata),
    .SLV_PREADY   (slv_pready),
    .SLV_PSLVERR  (slv_pslverr),
    .tmo_o        (tmo),
    .decerr_o     (decerr),
    .tmo_status_o (tmo_status),
    .clr_status_i (clr_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        psel;
    logic        pen;
    logic [11:0] addr;
    logic [3:0]  rdy;
    logic [3:0]  err;
    logic        clr;
    logic        s1_en;
    logic [3:0]  e_sel;
    logic        e_rdy;
    logic        e_err;
    logic [31:0] e_data;
    logic        e_tmo;
    logic        e_dec;
    logic [3:0]  e_stat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic psel, input logic pen, input logic [11:0] addr,
                              input logic [3:0] rdy, input logic [3:0] err, input logic clr,
                              input logic s1_en, input logic [3:0] e_sel, input logic e_rdy,
                              input logic e_err, input logic [31:0] e_data, input logic e_tmo,
                              input logic e_dec, input logic [3:0] e_stat);
    vec_t v;
    v.psel = psel; v.pen = pen; v.addr = addr; v.rdy = rdy; v.err = err;
    v.clr = clr; v.s1_en = s1_en; v.e_sel = e_sel; v.e_rdy = e_rdy; v.e_err = e_err;
    v.e_data = e_data; v.e_tmo = e_tmo; v.e_dec = e_dec; v.e_stat = e_stat;
    vecs.push_back(v);
  endfunction

  // Setup, seven silent wait cycles, then the expiring access cycle.
  function automatic void add_tmo(input logic [11:0] addr, input logic [3:0] sel,
                                  input logic clr_on_fire, input logic [3:0] stat);
    add(1, 0, addr, 4'b0000, 0, 0, 1, sel, 0, 0, 0, 0, 0, stat);
    for (int k = 0; k < 7; k++) add(1, 1, addr, ~sel, 0, 0, 1, sel, 0, 0, 0, 0, 0, stat);
    add(1, 1, addr, ~sel, 0, clr_on_fire, 1, 4'b0000, 1, 1, 0, 1, 0, stat);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic psel, input logic pen, input logic [11:0] addr,
                       input logic [3:0] rdy, input logic [3:0] err, input logic clr,
                       input logic s1_en);
    @(posedge clk);
    #1;
    bus.MST_PSEL    = psel;
    bus.MST_PENABLE = pen;
    bus.MST_PADDR   = addr;
    slv_pready      = rdy;
    slv_pslverr     = err;
    clr_status      = clr;
    slv_mask[1]     = s1_en ? 12'hF00 : 12'h000;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] sel, input logic rdy,
                            input logic err, input logic [31:0] data, input logic t,
                            input logic d, input logic [3:0] stat);
    @(negedge clk);
    check({tag, " psel"},    32'(slv_psel),        32'(sel));
    check({tag, " pready"},  32'(bus.MST_PREADY),  32'(rdy));
    check({tag, " pslverr"}, 32'(bus.MST_PSLVERR), 32'(err));
    check({tag, " prdata"},  bus.MST_PRDATA,       data);
    check({tag, " tmo"},     32'(tmo),             32'(t));
    check({tag, " decerr"},  32'(decerr),          32'(d));
    check({tag, " status"},  32'(tmo_status),      32'(stat));
  endtask

  initial begin
    rst             = 1'b1;
    bus.MST_PSEL    = 1'b0;
    bus.MST_PENABLE = 1'b0;
    bus.MST_PADDR   = '0;
    slv_pready      = '0;
    slv_pslverr     = '0;
    clr_status      = 1'b0;
    slv_addr[0] = 12'h000; slv_mask[0] = 12'hF00; slv_prdata[0] = D0;
    slv_addr[1] = 12'h100; slv_mask[1] = 12'hF00; slv_prdata[1] = D1;
    slv_addr[2] = 12'h100; slv_mask[2] = 12'hF00; slv_prdata[2] = D2;
    slv_addr[3] = 12'h300; slv_mask[3] = 12'hF00; slv_prdata[3] = D3;

    // read 0x104, slv1 ready after two waits; address wanders to slv0 mid-transfer
    add(1, 0, 12'h104, 4'b1101, 0, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h004, 4'b1101, 0, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h104, 4'b1101, 0, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h104, 4'b0010, 0, 0, 1, 4'b0010, 1, 0, D1, 0, 0, 0);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // overlapping windows: slv1 beats slv2, then slv2 once slv1 is disabled
    add(1, 0, 12'h180, 4'b0000, 0, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h180, 4'b0010, 0, 0, 1, 4'b0010, 1, 0, D1, 0, 0, 0);
    add(1, 0, 12'h180, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h180, 4'b0100, 0, 0, 0, 4'b0100, 1, 0, D2, 0, 0, 0);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // unmapped address
    add(1, 0, 12'hF00, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'hF00, 4'b1111, 0, 0, 1, 4'b0000, 1, 1, 0,  0, 1, 0);
    add(0, 0, 12'h000, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // back-to-back slv0 (with error) then slv1, no idle gap
    add(1, 0, 12'h010, 4'b0000, 4'b0000, 0, 1, 4'b0001, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h010, 4'b0001, 4'b0001, 0, 1, 4'b0001, 1, 1, D0, 0, 0, 0);
    add(1, 0, 12'h104, 4'b0000, 4'b0000, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h104, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 0, D1, 0, 0, 0);
    add(0, 0, 12'h000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // master drops PSEL during access, then a clean transfer
    add(1, 0, 12'h300, 4'b0000, 0, 0, 1, 4'b1000, 0, 0, 0,  0, 0, 0);
    add(0, 0, 12'h300, 4'b1000, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    add(1, 0, 12'h104, 4'b0000, 0, 0, 1, 4'b0010, 0, 0, 0,  0, 0, 0);
    add(1, 1, 12'h104, 4'b0010, 0, 0, 1, 4'b0010, 1, 0, D1, 0, 0, 0);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // watchdog on slv3, flag, clear
    add_tmo(12'h300, 4'b1000, 0, 4'b0000);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 12'h000, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    // ready arrives in the cycle the watchdog would expire
    add(1, 0, 12'h300, 4'b0000, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) add(1, 1, 12'h300, 4'b0000, 0, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    add(1, 1, 12'h300, 4'b1000, 0, 0, 1, 4'b1000, 1, 0, D3, 0, 0, 0);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0,  0, 0, 0);
    // timeout on slv0, then slv3 timeout coinciding with a clear
    add_tmo(12'h020, 4'b0001, 0, 4'b0000);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0001);
    add_tmo(12'h300, 4'b1000, 1, 4'b0001);
    add(0, 0, 12'h000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b1000);

    repeat (2) @(posedge clk);
    check_outs("reset", 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].psel, vecs[i].pen, vecs[i].addr, vecs[i].rdy, vecs[i].err,
            vecs[i].clr, vecs[i].s1_en);
      check_outs($sformatf("v%0d", i), vecs[i].e_sel, vecs[i].e_rdy, vecs[i].e_err,
                 vecs[i].e_data, vecs[i].e_tmo, vecs[i].e_dec, vecs[i].e_stat);
    end

    // reset while slv3 is stalling; status flag from the table is pending
    drive(1, 0, 12'h300, 4'b0000, 0, 0, 1);
    drive(1, 1, 12'h300, 4'b0000, 0, 0, 1);
    drive(1, 1, 12'h300, 4'b0000, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    check_outs("rst_mid", 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outs("rst_rel", 4'b0000, 0, 0, 0, 0, 0, 4'b0000);
    drive(0, 0, 12'h000, 4'b0000, 0, 0, 1);
    check_outs("post_idle", 4'b0000, 0, 0, 0, 0, 0, 4'b0000);

    // full watchdog interval after reset
    drive(1, 0, 12'h300, 4'b0000, 0, 0, 1);
    check_outs("post_setup", 4'b1000, 0, 0, 0, 0, 0, 4'b0000);
    for (int k = 0; k < 7; k++) drive(1, 1, 12'h300, 4'b0000, 0, 0, 1);
    check_outs("post_w7", 4'b1000, 0, 0, 0, 0, 0, 4'b0000);
    drive(1, 1, 12'h300, 4'b0000, 0, 0, 1);
    check_outs("post_tmo", 4'b0000, 1, 1, 0, 1, 0, 4'b0000);
    drive(0, 0, 12'h000, 4'b0000, 0, 0, 1);
    check_outs("post_flag", 4'b0000, 0, 0, 0, 0, 0, 4'b1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
